execute_load_store_req: RTL and testbench

- Issues one data-memory access per execute load/store command and derives the byte mask and byte shift from the address and access size.
- Holds the request until memory accepts it, waits for the response, and returns the captured data together with the mask/shift/shift-enable that the downstream load-data alignment stage consumes.
- Sits between execute control and the data-memory port, directly upstream of the load-data alignment stage.
- Only one access is outstanding at a time.

---
 rtl/execute_load_store_req_pkg.sv | 41 ++++
 rtl/execute_load_store_req_if.sv | 47 ++++
 rtl/execute_load_store_align.sv | 25 ++
 rtl/execute_load_store_req.sv | 134 +++++++++++++
 tb/tb_execute_load_store_req.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/execute_load_store_req_pkg.sv
// Shared types, constants and helpers for the execute load/store request block.
// Optional misalignment trap is enabled by defining MIST32_LSU_MISALIGN_CHECK_EN.
package execute_load_store_req_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } size_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Big-endian lanes: bit 3 is the byte at offset 0 (data[31:24]).
    localparam logic [3:0] MASK_BYTE    = 4'b1000;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    // Encoding 3 is folded onto a word access.
    function automatic size_e func_decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return SizeByte;
            2'd1:    return SizeHalf;
            default: return SizeWord;
        endcase
    endfunction

    function automatic logic [3:0] func_byte_mask(input size_e size, input logic [1:0] a);
        case (size)
            SizeByte: return MASK_BYTE >> a;
            SizeHalf: return a[1] ? MASK_HALF_LO : MASK_HALF_HI;
            default:  return MASK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/execute_load_store_req_if.sv
// Command, data-memory and load-alignment signals of the load/store request block.
// master = the request block itself, slave = execute control / memory / load stage.
interface execute_load_store_req_if #(
    parameter int unsigned P_ADDR_W = 32
);

    logic                cmd_valid;
    logic                cmd_busy;
    logic                cmd_rw;
    logic [1:0]          cmd_size;
    logic                cmd_shift_en;
    logic [P_ADDR_W-1:0] cmd_addr;
    logic [31:0]         cmd_data;

    logic                mem_req;
    logic                mem_busy;
    logic                mem_rw;
    logic [3:0]          mem_mask;
    logic [P_ADDR_W-1:0] mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_valid;
    logic [31:0]         mem_rdata;

    logic                done_valid;
    logic                done_err;
    logic [3:0]          ld_mask;
    logic [1:0]          ld_shift;
    logic                ld_shift_en;
    logic [31:0]         ld_data;

    modport master (
        input  cmd_valid, cmd_rw, cmd_size, cmd_shift_en, cmd_addr, cmd_data,
        output cmd_busy,
        output mem_req, mem_rw, mem_mask, mem_addr, mem_wdata,
        input  mem_busy, mem_valid, mem_rdata,
        output done_valid, done_err, ld_mask, ld_shift, ld_shift_en, ld_data
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_size, cmd_shift_en, cmd_addr, cmd_data,
        input  cmd_busy,
        input  mem_req, mem_rw, mem_mask, mem_addr, mem_wdata,
        output mem_busy, mem_valid, mem_rdata,
        input  done_valid, done_err, ld_mask, ld_shift, ld_shift_en, ld_data
    );

endinterface

// File: rtl/execute_load_store_align.sv
// Combinational byte-mask / byte-shift / store-lane generator for a single access.
module execute_load_store_align
    import execute_load_store_req_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  mask,
    output logic [1:0]  shift,
    output logic [31:0] lane_data
);

    always_comb begin
        mask      = func_byte_mask(size, addr_lo);
        shift     = addr_lo;
        lane_data = '0;
        case (size)
            // Byte at offset a lands in lane 3-a; ~a is 3-a for a 2-bit offset.
            SizeByte: lane_data = {24'h0, data[7:0]} << {~addr_lo, 3'b000};
            SizeHalf: lane_data = addr_lo[1] ? {16'h0, data[15:0]} : {data[15:0], 16'h0};
            default:  lane_data = data;
        endcase
    end

endmodule

// File: rtl/execute_load_store_req.sv
// Issues one data-memory access per execute load/store command and returns the load-stage info.
// Define MIST32_LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses without a bus cycle.
module execute_load_store_req
    import execute_load_store_req_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = 255,
    parameter int unsigned P_ADDR_W  = 32
) (
    input  logic                           iCLOCK,
    input  logic                           inRESET,
    execute_load_store_req_if.master       bus
);

    localparam int unsigned TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(P_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                rw_q;
    logic [P_ADDR_W-3:0] addr_q;
    logic [3:0]          mask_q;
    logic [31:0]         wdata_q;
    logic [1:0]          shift_q;
    logic                shift_en_q;
    logic [TW-1:0]       cnt_q;

    logic                done_err_q;
    logic [3:0]          ld_mask_q;
    logic [1:0]          ld_shift_q;
    logic                ld_shift_en_q;
    logic [31:0]         ld_data_q;

    size_e               size_c;
    logic [3:0]          mask_c;
    logic [1:0]          shift_c;
    logic [31:0]         lane_c;
    logic                misalign;
    logic                accept;
    logic                timeout_hit;
    logic                wait_end;

    assign size_c = func_decode_size(bus.cmd_size);

    execute_load_store_align u_align (
        .size      (size_c),
        .addr_lo   (bus.cmd_addr[1:0]),
        .data      (bus.cmd_data),
        .mask      (mask_c),
        .shift     (shift_c),
        .lane_data (lane_c)
    );

`ifdef MIST32_LSU_MISALIGN_CHECK_EN
    assign misalign = ((size_c == SizeHalf) && bus.cmd_addr[0])
                   || ((size_c == SizeWord) && (bus.cmd_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign accept      = (state_q == ST_IDLE) && bus.cmd_valid;
    assign timeout_hit = (P_TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign wait_end    = (state_q == ST_WAIT) && (bus.mem_valid || timeout_hit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) state_d = misalign ? ST_DONE : ST_REQ;
            ST_REQ:  if (!bus.mem_busy) state_d = ST_WAIT;
            ST_WAIT: if (bus.mem_valid || timeout_hit) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state_q       <= ST_IDLE;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            mask_q        <= '0;
            wdata_q       <= '0;
            shift_q       <= '0;
            shift_en_q    <= 1'b0;
            cnt_q         <= '0;
            done_err_q    <= 1'b0;
            ld_mask_q     <= '0;
            ld_shift_q    <= '0;
            ld_shift_en_q <= 1'b0;
            ld_data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rw_q       <= bus.cmd_rw;
                addr_q     <= bus.cmd_addr[P_ADDR_W-1:2];
                mask_q     <= mask_c;
                wdata_q    <= lane_c;
                shift_q    <= shift_c;
                shift_en_q <= bus.cmd_shift_en;
            end
            // Held at zero through REQ so WAIT always starts counting from 0.
            if (state_q == ST_REQ) begin
                cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + TW'(1);
            end
            if (accept && misalign) begin
                done_err_q    <= 1'b1;
                ld_mask_q     <= mask_c;
                ld_shift_q    <= shift_c;
                ld_shift_en_q <= bus.cmd_shift_en;
                ld_data_q     <= '0;
            end else if (wait_end) begin
                // A response wins over a timeout landing in the same cycle.
                done_err_q    <= !bus.mem_valid;
                ld_mask_q     <= mask_q;
                ld_shift_q    <= shift_q;
                ld_shift_en_q <= shift_en_q;
                ld_data_q     <= (bus.mem_valid && !rw_q) ? bus.mem_rdata : 32'h0;
            end
        end
    end

    assign bus.cmd_busy    = (state_q != ST_IDLE);
    assign bus.mem_req     = (state_q == ST_REQ);
    assign bus.mem_rw      = rw_q;
    assign bus.mem_mask    = mask_q;
    assign bus.mem_addr    = {addr_q, 2'b00};
    assign bus.mem_wdata   = wdata_q;
    assign bus.done_valid  = (state_q == ST_DONE);
    assign bus.done_err    = done_err_q;
    assign bus.ld_mask     = ld_mask_q;
    assign bus.ld_shift    = ld_shift_q;
    assign bus.ld_shift_en = ld_shift_en_q;
    assign bus.ld_data     = ld_data_q;

endmodule

// File: tb/tb_execute_load_store_req.sv
// Bench for execute_load_store_req: directed scenarios plus random accesses checked against
// a lane-by-lane behavioural model (honours MIST32_LSU_MISALIGN_CHECK_EN when defined).
module tb_execute_load_store_req;

    localparam int unsigned TO = 4;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;

    execute_load_store_req_if #(.P_ADDR_W(AW)) bus ();

    execute_load_store_req #(
        .P_TIMEOUT (TO),
        .P_ADDR_W  (AW)
    ) dut (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .bus     (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Byte k of the addressed region (offset from the low address) sits in lane 3-k; the
    // lowest address receives the most significant byte of the right-justified value.
    function automatic void model(input logic [1:0] size, input logic [1:0] a,
                                  input logic [31:0] d, output logic [3:0] mask,
                                  output logic [31:0] lanes, output bit mis);
        int n;
        int start;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        start = (n == 1) ? int'(a) : (n == 2) ? (int'(a) & 2) : 0;
        mask  = '0;
        lanes = '0;
        for (int k = start; k < start + n; k++) begin
            mask[3-k] = 1'b1;
            lanes[8*(3-k) +: 8] = d[8*(n-1-(k-start)) +: 8];
        end
`ifdef MIST32_LSU_MISALIGN_CHECK_EN
        mis = (int'(a) % n) != 0;
`else
        mis = 1'b0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_busy"}, 32'(bus.cmd_busy), 0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 0);
        check({tag, "_mem_rw"}, 32'(bus.mem_rw), 0);
        check({tag, "_mem_mask"}, 32'(bus.mem_mask), 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_done"}, 32'(bus.done_valid), 0);
        check({tag, "_err"}, 32'(bus.done_err), 0);
        check({tag, "_ld_mask"}, 32'(bus.ld_mask), 0);
        check({tag, "_ld_shift"}, 32'(bus.ld_shift), 0);
        check({tag, "_ld_shen"}, 32'(bus.ld_shift_en), 0);
        check({tag, "_ld_data"}, bus.ld_data, 0);
    endtask

    task automatic drive_cmd(input bit rw, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] data, input bit sh_en);
        bus.cmd_valid    = 1'b1;
        bus.cmd_rw       = rw;
        bus.cmd_size     = size;
        bus.cmd_addr     = addr;
        bus.cmd_data     = data;
        bus.cmd_shift_en = sh_en;
    endtask

    // One access from IDLE back to IDLE. busy = stall cycles in REQ; delay = WAIT cycles
    // before the response (delay >= TO means no response, i.e. timeout).
    task automatic run_txn(input bit rw, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input bit sh_en, input int busy,
                           input int delay, input logic [31:0] rdata);
        logic [3:0]  e_mask;
        logic [31:0] e_lanes;
        logic [31:0] e_ld;
        bit          mis;
        bit          tmo;
        int          last;
        model(size, addr[1:0], data, e_mask, e_lanes, mis);
        @(negedge clk);
        check("idle_cmd_busy", 32'(bus.cmd_busy), 0);
        drive_cmd(rw, size, addr, data, sh_en);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (mis) begin
            check("mis_done", 32'(bus.done_valid), 1);
            check("mis_err", 32'(bus.done_err), 1);
            check("mis_mem_req", 32'(bus.mem_req), 0);
            check("mis_ld_mask", 32'(bus.ld_mask), 32'(e_mask));
            check("mis_ld_data", bus.ld_data, 0);
            @(negedge clk);
            check("mis_done_clear", 32'(bus.done_valid), 0);
            return;
        end
        for (int i = 0; i <= busy; i++) begin
            check("req_mem_req", 32'(bus.mem_req), 1);
            check("req_cmd_busy", 32'(bus.cmd_busy), 1);
            check("req_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            check("req_mem_mask", 32'(bus.mem_mask), 32'(e_mask));
            check("req_mem_rw", 32'(bus.mem_rw), 32'(rw));
            if (rw) check("req_mem_wdata", bus.mem_wdata, e_lanes);
            bus.mem_busy  = (i < busy);
            // Responses outside WAIT must be ignored.
            bus.mem_valid = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            @(negedge clk);
        end
        bus.mem_busy = 1'b0;
        tmo  = (delay >= int'(TO));
        last = tmo ? int'(TO) - 1 : delay;
        for (int j = 0; j <= last; j++) begin
            check("wait_mem_req", 32'(bus.mem_req), 0);
            check("wait_done", 32'(bus.done_valid), 0);
            check("wait_cmd_busy", 32'(bus.cmd_busy), 1);
            bus.mem_valid = (j == delay);
            bus.mem_rdata = (j == delay) ? rdata : $urandom;
            @(negedge clk);
        end
        bus.mem_valid = 1'b0;
        e_ld = (tmo || rw) ? 32'h0 : rdata;
        check("done_valid", 32'(bus.done_valid), 1);
        check("done_cmd_busy", 32'(bus.cmd_busy), 1);
        check("done_err", 32'(bus.done_err), 32'(tmo));
        check("done_ld_mask", 32'(bus.ld_mask), 32'(e_mask));
        check("done_ld_shift", 32'(bus.ld_shift), 32'(addr[1:0]));
        check("done_ld_shen", 32'(bus.ld_shift_en), 32'(sh_en));
        check("done_ld_data", bus.ld_data, e_ld);
        @(negedge clk);
        check("post_done", 32'(bus.done_valid), 0);
        check("post_cmd_busy", 32'(bus.cmd_busy), 0);
        check("post_ld_data_hold", bus.ld_data, e_ld);
    endtask

    initial begin
        int n_done;
        int n_req;
        bit prev_done;

        bus.cmd_valid    = 1'b0;
        bus.cmd_rw       = 1'b0;
        bus.cmd_size     = 2'd0;
        bus.cmd_shift_en = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_data     = '0;
        bus.mem_busy     = 1'b0;
        bus.mem_valid    = 1'b0;
        bus.mem_rdata    = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed scenarios.
        run_txn(1'b0, 2'd0, 32'h0000_1003, 32'h0, 1'b0, 0, 0, 32'hAABB_CCDD);
        run_txn(1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234, 1'b1, 3, 1, 32'hDEAD_BEEF);
        run_txn(1'b0, 2'd2, 32'h0000_4000, 32'h0, 1'b0, 0, 100, 32'h0);
        run_txn(1'b0, 2'd2, 32'h0000_3001, 32'h0, 1'b1, 0, 2, 32'h1122_3344);
        run_txn(1'b1, 2'd0, 32'h0000_5001, 32'h0000_00A5, 1'b0, 1, TO - 1, 32'h0);

        // Reset while waiting for the response.
        @(negedge clk);
        drive_cmd(1'b0, 2'd2, 32'h0000_6000, 32'h0, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_in_wait", 32'(bus.cmd_busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_late_resp_done", 32'(bus.done_valid), 0);
            check("rst_late_resp_busy", 32'(bus.cmd_busy), 0);
            @(negedge clk);
        end
        run_txn(1'b0, 2'd1, 32'h0000_7000, 32'h0, 1'b0, 0, 0, 32'hCAFE_F00D);

        // Command held high continuously with an always-ready memory.
        @(negedge clk);
        drive_cmd(1'b0, 2'd2, 32'h0000_8000, 32'h0, 1'b0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h0BAD_CAFE;
        n_done    = 0;
        n_req     = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (prev_done) check("hold_accept_after_done", 32'(bus.cmd_busy), 0);
            if (bus.mem_req || bus.done_valid) check("hold_busy", 32'(bus.cmd_busy), 1);
            n_done += int'(bus.done_valid);
            n_req  += int'(bus.mem_req);
            prev_done = bus.done_valid;
        end
        bus.cmd_valid = 1'b0;
        bus.mem_valid = 1'b0;
        check("hold_done_count", 32'(n_done), 4);
        check("hold_req_count", 32'(n_req), 4);
        @(negedge clk);
        check("hold_idle", 32'(bus.cmd_busy), 0);

        // Random accesses against the model.
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 5)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
